// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg
//   Shared definitions for the RAM stream reader: ceiling-log2 helper used to
//   size address ports (also used by ram_dc), FSM state type and read-buffer
//   sizing constants.
package ram_stream_reader_pkg;

    // Ceiling log2; a 1-entry RAM still gets a 1-bit address.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } rsr_state_e;

    localparam int RD_BUF_DEPTH = 2;
    localparam int RD_BUF_CNT_W = 2;

endpackage

// File: rtl/ram_stream_reader_buf.sv
// ram_rd_buf
//   Two-entry FIFO of {data, last} between the RAM read pipeline and the
//   output stream. The head entry drives the stream directly from flops, so
//   out_data/out_last cannot change while a word waits for out_ready.
//   Ports:
//     clock, n_rst          clock, asynchronous active-low reset
//     in_valid/in_data/in_last   word captured from the RAM this edge
//     out_valid/out_data/out_last/out_ready   valid/ready stream side
//     count                 current occupancy (0..2), used for issue gating
module ram_rd_buf
    import ram_stream_reader_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic                    clock,
    input  logic                    n_rst,
    input  logic                    in_valid,
    input  logic [WORD_SIZE-1:0]    in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    output logic [WORD_SIZE-1:0]    out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [RD_BUF_CNT_W-1:0] count
);

    logic [WORD_SIZE-1:0]    data_q [RD_BUF_DEPTH];
    logic [WORD_SIZE-1:0]    data_d [RD_BUF_DEPTH];
    logic                    last_q [RD_BUF_DEPTH];
    logic                    last_d [RD_BUF_DEPTH];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [RD_BUF_CNT_W-1:0] count_q, count_d;
    logic                    push, pop;

    assign out_valid = (count_q != '0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_last  = out_valid & last_q[rd_ptr_q];
    assign count     = count_q;

    // The reader never pushes into a full buffer: issue gating accounts for
    // words in flight, so no overflow guard is needed here.
    assign push = in_valid;
    assign pop  = out_valid & out_ready;

    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            data_d[wr_ptr_q] = in_data;
            last_d[wr_ptr_q] = in_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side controller for a single-port, 1-cycle-latency RAM with no read
//   enable. A start pulse reads `length` consecutive words from `base_addr`
//   (wrapping at RAM_SIZE) and streams them out over valid/ready.
//   Ports:
//     clock, n_rst                  clock, asynchronous active-low reset
//     start, base_addr, length      request, sampled only while idle
//     busy, done                    status; done pulses once per transfer
//     rd_addr, rd_data              RAM read port (data one clock after addr)
//     out_data/out_valid/out_ready/out_last   output stream
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing addresses while buffer space allows
//   ST_DRAIN | all addresses issued, waiting for the last word handshake
//   ST_FIN   | one-cycle done pulse, then back to idle
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter  int WORD_SIZE = 8,
    parameter  int RAM_SIZE  = 1024,
    localparam int ADDR_BITW = log2_ceil(RAM_SIZE)
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [ADDR_BITW-1:0] base_addr,
    input  logic [ADDR_BITW:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITW-1:0] rd_addr,
    input  logic [WORD_SIZE-1:0] rd_data,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int CNT_BITW = ADDR_BITW + 1;

    rsr_state_e              state_q, state_d;
    logic [ADDR_BITW-1:0]    rd_addr_q, rd_addr_d;
    logic [CNT_BITW-1:0]     remaining_q, remaining_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;

    logic [CNT_BITW-1:0]     len_clamped;
    logic [ADDR_BITW-1:0]    addr_next;
    logic [RD_BUF_CNT_W-1:0] buf_count;
    logic                    buf_valid;
    logic                    buf_last;
    logic                    buf_pop;
    logic [2:0]              occupancy;
    logic [2:0]              space_limit;
    logic                    slot_free;
    logic                    issue;

    assign len_clamped = (length > CNT_BITW'(RAM_SIZE)) ? CNT_BITW'(RAM_SIZE) : length;
    assign addr_next   = (rd_addr_q == ADDR_BITW'(RAM_SIZE - 1)) ? '0
                                                                 : rd_addr_q + ADDR_BITW'(1);

    assign buf_pop = buf_valid & out_ready;

    // A word leaving the buffer this cycle frees its slot in time for the
    // word issued now, which arrives two edges later. Counting that pop is
    // what lets the stream sustain one word per cycle with only two entries.
    assign occupancy   = {1'b0, buf_count} + {2'b00, inflight_q};
    assign space_limit = 3'd2 + {2'b00, buf_pop};
    assign slot_free   = (occupancy < space_limit);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_addr_d   = base_addr;
                    remaining_d = len_clamped;
                    state_d     = (len_clamped == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (slot_free) begin
                    issue       = 1'b1;
                    remaining_d = remaining_q - CNT_BITW'(1);
                    if (remaining_q == CNT_BITW'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rd_addr_d = addr_next;
                    end
                end
            end
            ST_DRAIN: begin
                if (buf_pop && buf_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The address presented this cycle is sampled by the RAM at the
        // coming edge; its data is on rd_data for the following cycle.
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == CNT_BITW'(1));
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            rd_addr_q       <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FIN);
    assign rd_addr = rd_addr_q;

    ram_rd_buf #(
        .WORD_SIZE (WORD_SIZE)
    ) u_rd_buf (
        .clock     (clock),
        .n_rst     (n_rst),
        .in_valid  (inflight_q),
        .in_data   (rd_data),
        .in_last   (inflight_last_q),
        .out_valid (buf_valid),
        .out_data  (out_data),
        .out_last  (buf_last),
        .out_ready (out_ready),
        .count     (buf_count)
    );

    assign out_valid = buf_valid;
    assign out_last  = buf_last;

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

    localparam int WS = 8;
    localparam int RS = 1024;
    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done;
    logic [AW-1:0] rd_addr;
    logic [WS-1:0] rd_data;
    logic [WS-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;

    logic [WS-1:0] mem [RS];

    ram_stream_reader #(.WORD_SIZE(WS), .RAM_SIZE(RS)) dut (
        .clock     (clock),
        .n_rst     (n_rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    // Attached RAM: no enable, no reset, one clock of read latency.
    always @(posedge clock) rd_data <= mem[rd_addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: each accepted request expands into its list of
    // {last, word} from the RAM image; busy/done follow the transfer life.
    logic [WS:0]   exp_q [$];
    bit            act = 0;
    bit            done_due = 0;
    bit            prev_stall = 0;
    logic [WS-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clock) begin
        logic [WS:0] e;
        bit          hs, last_hs, accepted;
        int          len;
        if (!n_rst) begin
            chk("rst_busy",  busy,      0);
            chk("rst_done",  done,      0);
            chk("rst_valid", out_valid, 0);
            chk("rst_last",  out_last,  0);
            chk("rst_addr",  rd_addr,   0);
            chk("rst_data",  out_data,  0);
            exp_q.delete();
            act        = 0;
            done_due   = 0;
            prev_stall = 0;
        end else begin
            chk("busy", busy, act);
            chk("done", done, done_due);
            chk("valid_unexpected", out_valid && (exp_q.size() == 0), 0);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data",  out_data,  prev_data);
                chk("stall_last",  out_last,  prev_last);
            end
            hs      = out_valid && out_ready;
            last_hs = 0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", out_data, 64'hffff_ffff_ffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", out_data, e[WS-1:0]);
                    chk("last", out_last, e[WS]);
                    last_hs = e[WS];
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;

            accepted = start && !act;
            if (done_due) act = 0;
            done_due = last_hs;
            if (accepted) begin
                act = 1;
                len = (int'(length) > RS) ? RS : int'(length);
                for (int k = 0; k < len; k++) begin
                    exp_q.push_back({(k == len - 1), mem[(int'(base_addr) + k) % RS]});
                end
                if (len == 0) done_due = 1;
            end
        end
    end

    int mode = 0;  // 0: ready high, 1: ready random, 2: ready low

    task automatic tick();
        @(posedge clock);
        #1;
        start = 1'b0;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic do_start(input int b, input int len);
        tick();
        start     = 1'b1;
        base_addr = AW'(b);
        length    = (AW+1)'(len);
    endtask

    task automatic wait_done(input int budget, input bit spurious);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (spurious && $urandom_range(0, 7) == 0) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                length    = (AW+1)'($urandom);
            end
            sample();
            seen = done;
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < RS; i++) begin
            mem[i] = rnd ? WS'($urandom) : WS'(i);
        end
    endtask

    initial begin
        repeat (200000) @(posedge clock);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int            first_v;
        int            hs_cnt;
        logic [AW-1:0] last_a;
        logic [AW-1:0] addr_q [$];
        int            b, len;

        fill(0);
        repeat (3) tick();
        n_rst = 1'b1;
        repeat (2) tick();

        // Incrementing data, base 0, length 8, ready held high
        mode = 0;
        do_start(0, 8);
        first_v = 0;
        for (int i = 1; i <= 10 && first_v == 0; i++) begin
            tick();
            sample();
            if (out_valid) first_v = i;
        end
        chk("first_valid_cycle", first_v, 3);
        chk("word0", out_data, 0);
        for (int w = 1; w < 8; w++) begin
            tick();
            sample();
            chk("contig_valid", out_valid, 1);
            chk("contig_data", out_data, w);
        end
        chk("last_on_7", out_last, 1);
        tick(); sample();
        chk("done_after_last", done, 1);
        tick(); sample();
        chk("idle_after_done", busy, 0);

        // Wrap across the top of the RAM
        last_a = rd_addr;
        addr_q.delete();
        do_start(1020, 8);
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            sample();
            if (rd_addr != last_a) addr_q.push_back(rd_addr);
            last_a = rd_addr;
        end
        chk("wrap_done", done, 1);
        chk("wrap_addr_count", addr_q.size(), 8);
        for (int i = 0; i < addr_q.size() && i < 8; i++) begin
            chk("wrap_addr", addr_q[i], (1020 + i) % RS);
        end
        tick();

        // Length 16 under random back-pressure
        fill(1);
        mode = 1;
        do_start(int'($urandom_range(0, RS - 1)), 16);
        wait_done(300, 1);
        tick();

        // Zero length: done one cycle after acceptance, busy for one cycle
        mode = 0;
        do_start(5, 0);
        tick(); sample();
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        chk("len0_valid", out_valid, 0);
        tick(); sample();
        chk("len0_busy_after", busy, 0);
        chk("len0_done_after", done, 0);

        // Single word held by back-pressure
        mode = 2;
        do_start(9, 1);
        repeat (5) begin tick(); sample(); end
        chk("len1_valid", out_valid, 1);
        chk("len1_last", out_last, 1);
        chk("len1_data", out_data, mem[9]);
        chk("len1_no_done", done, 0);
        mode = 0;
        wait_done(10, 0);
        tick();

        // Ignored start while busy, then reset at word 4 of 10
        do_start(100, 10);
        tick();
        start = 1'b1; base_addr = AW'(500); length = (AW+1)'(3);
        sample();
        hs_cnt = 0;
        for (int i = 0; i < 40 && hs_cnt < 4; i++) begin
            tick();
            sample();
            if (out_valid && out_ready) hs_cnt++;
        end
        chk("reached_word4", hs_cnt, 4);
        tick();
        n_rst = 1'b0;
        #1;
        chk("midrst_busy",  busy,      0);
        chk("midrst_done",  done,      0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_last",  out_last,  0);
        chk("midrst_addr",  rd_addr,   0);
        chk("midrst_data",  out_data,  0);
        repeat (2) tick();
        n_rst = 1'b1;
        repeat (3) begin tick(); sample(); end
        do_start(1018, 9);
        wait_done(40, 0);
        tick();

        // Full ring from a nonzero base, and an over-long request
        mode = 1;
        do_start(5, RS);
        wait_done(6000, 1);
        tick();
        do_start(300, 1500);
        wait_done(6000, 1);
        tick();

        // Random transfers
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) fill(1);
            mode = int'($urandom_range(0, 1));
            b    = int'($urandom_range(0, RS - 1));
            len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047))
                                               : int'($urandom_range(0, 20));
            do_start(b, len);
            wait_done(6000, 1);
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick(); sample();
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
